// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types for the EXE-stage hazard controller: forwarding select codes,
// memory-wait FSM states and the pipeline shadow-slot record.
package exe_hazard_ctrl_pkg;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } mem_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two_src;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
  } slot_t;

  function automatic logic slot_match(input slot_t s, input logic [3:0] r);
    return s.valid && s.wb_en && (s.dest == r);
  endfunction

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// ID-stage instruction fields in, forwarding selects and stall controls out.
interface exe_hazard_ctrl_if;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       id_mem_w_en;
  logic       branch_taken;
  logic [1:0] sel_src_1;
  logic [1:0] sel_src_2;
  logic       hazard;
  logic       freeze;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest,
           id_wb_en, id_mem_r_en, id_mem_w_en, branch_taken,
    input  sel_src_1, sel_src_2, hazard, freeze
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest,
           id_wb_en, id_mem_r_en, id_mem_w_en, branch_taken,
    output sel_src_1, sel_src_2, hazard, freeze
  );
endinterface

// File: rtl/exe_hazard_ctrl_mem_wait_fsm.sv
// Holds the pipeline frozen while a load/store sits in MEM: MEM_WAIT cycles
// per access, the last of which releases the pipeline.
module mem_wait_fsm
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_acc,
  output logic freeze
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT - 2);

  mem_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // RELEASE never samples mem_acc, so the access leaving MEM is not recounted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    freeze    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_acc && (MEM_WAIT > 1)) begin
          freeze    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (MEM_WAIT == 2) ? RELEASE : BUSY;
        end
      end
      BUSY: begin
        freeze  = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage controller: shadows EXE/MEM/WB register tags to drive operand
// forwarding selects, the load-use/RAW stall and the memory-wait freeze.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 4,
  parameter bit FORWARD_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  exe_hazard_ctrl_if.slave bus
);

  slot_t exe_q, mem_q, wb_q, id_slot;
  logic  mem_acc, freeze, hazard, dep_exe, dep_mem;

  assign id_slot = '{valid:    bus.id_valid,
                     src1:     bus.id_src1,
                     src2:     bus.id_src2,
                     two_src:  bus.id_two_src,
                     dest:     bus.id_dest,
                     wb_en:    bus.id_wb_en,
                     mem_r_en: bus.id_mem_r_en,
                     mem_w_en: bus.id_mem_w_en};

  // A load in MEM only has its address, so it cannot source a forward.
  function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic rd,
                                         input slot_t ex, input slot_t mm,
                                         input slot_t wb);
    if (!FORWARD_EN || !ex.valid || !rd) return SEL_REG;
    if (slot_match(mm, r) && !mm.mem_r_en) return SEL_MEM;
    if (slot_match(wb, r)) return SEL_WB;
    return SEL_REG;
  endfunction

  assign bus.sel_src_1 = fwd_sel(exe_q.src1, 1'b1, exe_q, mem_q, wb_q);
  assign bus.sel_src_2 = fwd_sel(exe_q.src2, exe_q.two_src, exe_q, mem_q, wb_q);

  always_comb begin
    dep_exe = slot_match(exe_q, bus.id_src1) ||
              (bus.id_two_src && slot_match(exe_q, bus.id_src2));
    dep_mem = slot_match(mem_q, bus.id_src1) ||
              (bus.id_two_src && slot_match(mem_q, bus.id_src2));
    if (FORWARD_EN) hazard = bus.id_valid && dep_exe && exe_q.mem_r_en;
    else            hazard = bus.id_valid && (dep_exe || dep_mem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      exe_q <= (hazard || bus.branch_taken || !bus.id_valid) ? '0 : id_slot;
      mem_q <= exe_q;
      wb_q  <= mem_q;
    end
  end

  assign mem_acc = mem_q.valid && (mem_q.mem_r_en || mem_q.mem_w_en);

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) u_mem_wait_fsm (
    .clk     (clk),
    .rst     (rst),
    .mem_acc (mem_acc),
    .freeze  (freeze)
  );

  assign bus.hazard = hazard;
  assign bus.freeze = freeze;

  // MEM and WB slots carry full records but only their destination is consulted.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{exe_q.mem_w_en,
                              mem_q.src1, mem_q.src2, mem_q.two_src,
                              wb_q.src1, wb_q.src2, wb_q.two_src,
                              wb_q.mem_r_en, wb_q.mem_w_en};

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Self-checking bench for exe_hazard_ctrl: four parameter variants driven with
// the same ID stream, directed scenarios plus random traffic against a model.
module tb_exe_hazard_ctrl;

  localparam int NI = 4;
  // variants: 0 = (wait 4, fwd), 1 = (wait 4, no fwd), 2 = (wait 1, fwd), 3 = (wait 2, fwd)
  localparam logic [3:0][4:0] MWP = {5'd2, 5'd1, 5'd4, 5'd4};
  localparam logic [3:0]      FEP = 4'b1101;

  typedef struct packed {
    logic       v;
    logic [3:0] s1, s2, d;
    logic       two, wb, mr, mw;
  } ins_t;
  localparam ins_t NOP = '0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_two_src = 1'b0, id_wb_en = 1'b0;
  logic       id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, branch_taken = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;

  logic [1:0] o_s1 [NI];
  logic [1:0] o_s2 [NI];
  logic       o_hz [NI];
  logic       o_fz [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    exe_hazard_ctrl_if bus ();
    assign bus.id_valid     = id_valid;
    assign bus.id_src1      = id_src1;
    assign bus.id_src2      = id_src2;
    assign bus.id_two_src   = id_two_src;
    assign bus.id_dest      = id_dest;
    assign bus.id_wb_en     = id_wb_en;
    assign bus.id_mem_r_en  = id_mem_r_en;
    assign bus.id_mem_w_en  = id_mem_w_en;
    assign bus.branch_taken = branch_taken;
    exe_hazard_ctrl #(.MEM_WAIT(int'(MWP[g])), .FORWARD_EN(FEP[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign o_s1[g] = bus.sel_src_1;
    assign o_s2[g] = bus.sel_src_2;
    assign o_hz[g] = bus.hazard;
    assign o_fz[g] = bus.freeze;
  end

  // Reference model: which instruction sits in each stage, and how long the
  // MEM occupant has been there.
  ins_t ex_m [NI];
  ins_t mm_m [NI];
  ins_t wb_m [NI];
  int   age  [NI];
  int   n_tests = 0, n_fail = 0;

  function automatic ins_t op(input int s1, input int s2, input int two,
                              input int d, input int wb, input int mr, input int mw);
    ins_t i;
    i.v = 1'b1; i.s1 = 4'(s1); i.s2 = 4'(s2); i.d = 4'(d);
    i.two = (two != 0); i.wb = (wb != 0); i.mr = (mr != 0); i.mw = (mw != 0);
    return i;
  endfunction

  function automatic logic hit(input ins_t s, input logic [3:0] r);
    return s.v && s.wb && (s.d == r);
  endfunction

  function automatic logic [1:0] m_sel(input int k, input logic [3:0] r, input logic rd);
    if (!FEP[k] || !ex_m[k].v || !rd) return 2'b00;
    if (hit(mm_m[k], r) && !mm_m[k].mr) return 2'b01;
    if (hit(wb_m[k], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_dep(input ins_t s);
    return hit(s, id_src1) || (id_two_src && hit(s, id_src2));
  endfunction

  function automatic logic m_hazard(input int k);
    if (!id_valid) return 1'b0;
    if (FEP[k]) return m_dep(ex_m[k]) && ex_m[k].mr;
    return m_dep(ex_m[k]) || m_dep(mm_m[k]);
  endfunction

  function automatic logic m_freeze(input int k);
    return mm_m[k].v && (mm_m[k].mr || mm_m[k].mw) && (age[k] < int'(MWP[k]) - 1);
  endfunction

  task automatic drive(input ins_t i, input logic bt);
    id_valid = i.v; id_src1 = i.s1; id_src2 = i.s2; id_two_src = i.two;
    id_dest = i.d; id_wb_en = i.wb; id_mem_r_en = i.mr; id_mem_w_en = i.mw;
    branch_taken = bt;
    #1;
  endtask

  task automatic tick();
    for (int k = 0; k < NI; k++) begin
      logic fz, hz;
      fz = m_freeze(k);
      hz = m_hazard(k);
      if (rst) begin
        ex_m[k] = NOP; mm_m[k] = NOP; wb_m[k] = NOP; age[k] = 0;
      end else if (!fz) begin
        wb_m[k] = mm_m[k];
        mm_m[k] = ex_m[k];
        ex_m[k] = (hz || branch_taken || !id_valid) ? NOP :
                  '{id_valid, id_src1, id_src2, id_dest, id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en};
        age[k] = 0;
      end else begin
        age[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(NOP, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(NOP, 1'b0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if ({o_s1[k], o_s2[k], o_hz[k], o_fz[k]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got s1=%b s2=%b hz=%b fz=%b want all 0", k, o_s1[k], o_s2[k], o_hz[k], o_fz[k]);
      end
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(op(2, 3, 1, 1, 1, 0, 0), 1'b0); tick();        // ADD r1,r2,r3
    drive(op(1, 3, 1, 2, 1, 0, 0), 1'b0);                // SUB r2,r1,r3
    n_tests++; if (o_hz[0] !== 1'b0) begin n_fail++; $display("FAIL fwd_no_hazard: got %b want 0", o_hz[0]); end
    tick();
    drive(op(1, 0, 0, 7, 1, 0, 0), 1'b0);                // AND r7,r1
    n_tests++; if (o_s1[0] !== 2'b01) begin n_fail++; $display("FAIL fwd_mem_s1: got %b want 01", o_s1[0]); end
    n_tests++; if (o_s2[0] !== 2'b00) begin n_fail++; $display("FAIL fwd_mem_s2: got %b want 00", o_s2[0]); end
    tick();
    drive(NOP, 1'b0);
    n_tests++; if (o_s1[0] !== 2'b10) begin n_fail++; $display("FAIL fwd_wb_s1: got %b want 10", o_s1[0]); end
  endtask

  task automatic test_load_use();
    logic [3:0] exp_fz;
    exp_fz = 4'b0111;
    do_reset();
    drive(op(0, 0, 0, 4, 1, 1, 0), 1'b0); tick();        // LDR r4
    drive(op(4, 4, 1, 5, 1, 0, 0), 1'b0);                // ADD r5,r4,r4 waits in ID
    n_tests++; if (o_hz[0] !== 1'b1) begin n_fail++; $display("FAIL lu_hazard: got %b want 1", o_hz[0]); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (o_hz[0] !== 1'b0) begin n_fail++; $display("FAIL lu_bubble c%0d: got %b want 0", c, o_hz[0]); end
      n_tests++; if (o_fz[0] !== exp_fz[c]) begin n_fail++; $display("FAIL lu_freeze c%0d: got %b want %b", c, o_fz[0], exp_fz[c]); end
    end
    tick();
    n_tests++; if (o_s1[0] !== 2'b10) begin n_fail++; $display("FAIL lu_s1: got %b want 10", o_s1[0]); end
    n_tests++; if (o_s2[0] !== 2'b10) begin n_fail++; $display("FAIL lu_s2: got %b want 10", o_s2[0]); end
    drive(NOP, 1'b0);
  endtask

  task automatic test_mem_priority();
    do_reset();
    drive(op(0, 0, 0, 6, 1, 0, 0), 1'b0); tick();
    drive(op(1, 1, 0, 6, 1, 0, 0), 1'b0); tick();
    drive(op(6, 6, 1, 9, 1, 0, 0), 1'b0); tick();
    drive(NOP, 1'b0);
    n_tests++; if (o_s1[0] !== 2'b01) begin n_fail++; $display("FAIL prio_s1: got %b want 01", o_s1[0]); end
    n_tests++; if (o_s2[0] !== 2'b01) begin n_fail++; $display("FAIL prio_s2: got %b want 01", o_s2[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_fz, exp_hz;
    exp_fz = 8'b0111_0111;
    exp_hz = 8'b0000_1111;
    do_reset();
    drive(op(0, 1, 1, 0, 0, 0, 1), 1'b0); tick();        // STR r1,[r0]
    drive(op(2, 0, 0, 8, 1, 1, 0), 1'b0); tick();        // LDR r8
    drive(op(8, 0, 0, 3, 1, 0, 0), 1'b0);                // ADD r3,r8 stalls behind both
    for (int c = 0; c < 8; c++) begin
      n_tests++; if (o_fz[0] !== exp_fz[c]) begin n_fail++; $display("FAIL b2b_freeze c%0d: got %b want %b", c, o_fz[0], exp_fz[c]); end
      n_tests++; if (o_hz[0] !== exp_hz[c]) begin n_fail++; $display("FAIL b2b_hazard c%0d: got %b want %b", c, o_hz[0], exp_hz[c]); end
      tick();
    end
    drive(NOP, 1'b0);
    n_tests++; if (o_s1[0] !== 2'b10) begin n_fail++; $display("FAIL b2b_s1: got %b want 10", o_s1[0]); end
  endtask

  task automatic test_no_forward();
    logic [2:0] exp_hz;
    exp_hz = 3'b011;
    do_reset();
    drive(op(2, 3, 1, 1, 1, 0, 0), 1'b0); tick();        // ADD r1
    drive(op(1, 0, 0, 2, 1, 0, 0), 1'b0);                // ORR r2,r1
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (o_hz[1] !== exp_hz[c]) begin n_fail++; $display("FAIL nofwd_hazard c%0d: got %b want %b", c, o_hz[1], exp_hz[c]); end
      if (c == 1) begin
        n_tests++; if (o_s1[0] !== 2'b01) begin n_fail++; $display("FAIL nofwd_ref_s1: got %b want 01", o_s1[0]); end
      end
      tick();
    end
    drive(NOP, 1'b0);
    n_tests++; if (o_s1[1] !== 2'b00 || o_s2[1] !== 2'b00) begin n_fail++; $display("FAIL nofwd_sel: got %b/%b want 00/00", o_s1[1], o_s2[1]); end
  endtask

  task automatic test_branch_freeze();
    logic [3:0] exp_fz;
    exp_fz = 4'b0111;
    do_reset();
    drive(op(0, 0, 0, 9, 1, 1, 0), 1'b0); tick();        // LDR r9
    drive(op(0, 0, 0, 10, 1, 0, 0), 1'b0); tick();       // ADD r10 holds in EXE
    drive(op(10, 0, 0, 11, 1, 0, 0), 1'b1);              // SUB r11,r10 under a taken branch
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (o_fz[0] !== exp_fz[c]) begin n_fail++; $display("FAIL br_freeze c%0d: got %b want %b", c, o_fz[0], exp_fz[c]); end
      tick();
    end
    drive(op(10, 0, 0, 12, 1, 0, 0), 1'b0);
    n_tests++; if (o_s1[0] !== 2'b00) begin n_fail++; $display("FAIL br_flushed: got %b want 00", o_s1[0]); end
    tick();
    drive(NOP, 1'b0);
    n_tests++; if (o_s1[0] !== 2'b10) begin n_fail++; $display("FAIL br_after: got %b want 10", o_s1[0]); end
  endtask

  task automatic test_rst_busy();
    do_reset();
    drive(op(0, 0, 0, 4, 1, 1, 0), 1'b0); tick();
    drive(op(4, 0, 0, 5, 1, 0, 0), 1'b0); tick(); tick();
    n_tests++; if (o_fz[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", o_fz[0]); end
    rst = 1'b1; tick(); rst = 1'b0;
    drive(NOP, 1'b0);
    n_tests++; if (o_fz[0] !== 1'b0) begin n_fail++; $display("FAIL rst_freeze: got %b want 0", o_fz[0]); end
    n_tests++; if (o_s1[0] !== 2'b00 || o_s2[0] !== 2'b00) begin n_fail++; $display("FAIL rst_sel: got %b/%b want 00/00", o_s1[0], o_s2[0]); end
    tick();
    n_tests++; if (o_fz[0] !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", o_fz[0]); end
  endtask

  task automatic test_wait_limits();
    int fz_cnt [NI];
    int exp_cnt [NI];
    for (int k = 0; k < NI; k++) begin
      fz_cnt[k] = 0;
      exp_cnt[k] = int'(MWP[k]) - 1;
    end
    do_reset();
    drive(op(0, 1, 1, 0, 0, 0, 1), 1'b0); tick();
    drive(NOP, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NI; k++) fz_cnt[k] += int'(o_fz[k]);
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      n_tests++; if (fz_cnt[k] != exp_cnt[k]) begin n_fail++; $display("FAIL wait_len[%0d]: got %0d freeze cycles want %0d", k, fz_cnt[k], exp_cnt[k]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ins_t i;
      logic bt;
      i.v   = ($urandom_range(0, 7) != 0);
      i.s1  = 4'($urandom_range(0, 3));
      i.s2  = 4'($urandom_range(0, 3));
      i.d   = 4'($urandom_range(0, 3));
      i.two = ($urandom_range(0, 1) != 0);
      i.mr  = ($urandom_range(0, 5) == 0);
      i.mw  = !i.mr && ($urandom_range(0, 7) == 0);
      i.wb  = i.mr || ($urandom_range(0, 3) != 0);
      bt    = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      drive(i, bt);
      for (int k = 0; k < NI; k++) begin
        logic [1:0] e1, e2;
        logic eh, ef;
        e1 = m_sel(k, ex_m[k].s1, 1'b1);
        e2 = m_sel(k, ex_m[k].s2, ex_m[k].two);
        eh = m_hazard(k);
        ef = m_freeze(k);
        n_tests++; if (o_s1[k] !== e1) begin n_fail++; $display("FAIL rnd_s1[%0d] c%0d: got %b want %b", k, c, o_s1[k], e1); end
        n_tests++; if (o_s2[k] !== e2) begin n_fail++; $display("FAIL rnd_s2[%0d] c%0d: got %b want %b", k, c, o_s2[k], e2); end
        n_tests++; if (o_hz[k] !== eh) begin n_fail++; $display("FAIL rnd_hazard[%0d] c%0d: got %b want %b", k, c, o_hz[k], eh); end
        n_tests++; if (o_fz[k] !== ef) begin n_fail++; $display("FAIL rnd_freeze[%0d] c%0d: got %b want %b", k, c, o_fz[k], ef); end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_priority();
    test_back_to_back();
    test_no_forward();
    test_branch_freeze();
    test_rst_busy();
    test_wait_limits();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_hazard_ctrl.md
# exe_hazard_ctrl

Pipeline controller for the EXE stage of the 5-stage ARM core. It keeps a shadow copy of the register tags held in EXE, MEM and WB, and from them drives the `sel_src_1`/`sel_src_2` forwarding selects of the EXE operand muxes. It also raises the load-use/RAW `hazard` stall and sequences the multi-cycle data-memory access by asserting `freeze` for a configurable number of wait states. It sits beside the ID/EXE pipeline register and is the single owner of stall, bubble and forwarding decisions.

## Interface
- `MEM_WAIT`, default 4: total cycles a load/store occupies MEM. Legal range 1..16.
- `FORWARD_EN`, default 1: 1 enables forwarding; 0 forces selects to 00 and stalls on every RAW dependency.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_src1` in 4: Rn of the ID instruction.
- `id_src2` in 4: Rm/Rd source of the ID instruction.
- `id_two_src` in 1: `id_src2` is a real read (register operand or store).
- `id_dest` in 4: destination of the ID instruction.
- `id_wb_en`, `id_mem_r_en`, `id_mem_w_en` in 1 each: control bits of the ID instruction.
- `branch_taken` in 1: taken branch resolved in EXE; flushes the ID instruction.
- `sel_src_1`, `sel_src_2` out 2 each: forwarding selects for the EXE instruction. 00 = register file, 01 = MEM-stage value, 10 = WB value.
- `hazard` out 1: hold PC and IF/ID, insert a bubble into EXE.
- `freeze` out 1: hold every pipeline register; memory access in progress.

## Operation
- Shadow slots EXE, MEM and WB. Each holds valid, src1, src2, two_src, dest, wb_en, mem_r_en and mem_w_en. MEM and WB use only the destination fields.
- Slot advance happens on every cycle where `freeze`=0:
  - EXE loads the ID fields. It loads a bubble (valid=0) instead if `hazard`=1, `branch_taken`=1 or `id_valid`=0.
  - MEM takes EXE, and WB takes MEM.
- While `freeze`=1, all slots hold.
- A slot matches register r when: valid, wb_en, and dest==r.
- Forwarding (`FORWARD_EN`=1), applied separately to src1 and to src2 (src2 only if two_src):
  - Select 01 if the MEM slot matches and MEM.mem_r_en=0. A load in MEM carries an address, not data.
  - Otherwise select 10 if the WB slot matches.
  - Otherwise select 00.
  - MEM has priority over WB.
  - An invalid EXE slot gives 00 on both selects.
- Hazard when `FORWARD_EN`=1: `hazard`=1 iff `id_valid`, the EXE slot matches `id_src1` (or `id_src2` with `id_two_src`), and EXE.mem_r_en=1.
- Hazard when `FORWARD_EN`=0: `hazard`=1 iff `id_valid` and the EXE or MEM slot matches `id_src1` (or `id_src2` with `id_two_src`).
- Memory FSM has states IDLE, BUSY and RELEASE, with a 4-bit counter `cnt`. A memory access (mem_acc) is a valid MEM slot with mem_r_en or mem_w_en set.
  - IDLE: if mem_acc and `MEM_WAIT`>1, set `freeze`=1 and `cnt`<=`MEM_WAIT`-2. Next state is RELEASE if `MEM_WAIT`==2, otherwise BUSY.
  - IDLE: if mem_acc and `MEM_WAIT`==1, there is no freeze and the state stays IDLE.
  - BUSY: `freeze`=1 and `cnt` decrements. Move to RELEASE when `cnt`==1.
  - RELEASE: `freeze`=0 so the pipeline advances. Next state is IDLE. The access still in MEM this cycle is not recounted.
  - A memory op entering MEM directly behind another is detected in the following IDLE cycle. Back-to-back accesses therefore each take `MEM_WAIT` cycles.
- `branch_taken` is ignored while `freeze`=1. It is applied on the release cycle, because EXE holds the branch throughout the freeze.
- `hazard` is still computed during a freeze, but it has no effect because slots hold.
- Writes to r15 receive no special treatment.

## Timing
- `sel_src_*` and `hazard` are combinational from the slot registers and the ID inputs, and are valid in the same cycle.
- `freeze` is combinational from the FSM state and the MEM slot. It asserts in the first cycle the access is in MEM.
- A load/store stays in MEM for exactly `MEM_WAIT` cycles, of which `MEM_WAIT`-1 have `freeze`=1.
- A load-use dependency costs 1 bubble. The dependent instruction then forwards from WB (select 10).
- Reset state: all slots invalid, FSM in IDLE, `cnt`=0, `sel_src_1`=`sel_src_2`=00, `hazard`=0, `freeze`=0.
- `rst` asserted mid-access abandons the access and returns to IDLE on the next edge.

## Structure
- A shared package holds:
  - sel encodings `SEL_REG`=2'b00, `SEL_MEM`=2'b01, `SEL_WB`=2'b10;
  - FSM state typedef (IDLE, BUSY, RELEASE);
  - the slot struct typedef.
- One sub-module, `mem_wait_fsm`, holds the state, the counter and the `freeze` output, with inputs `clk`, `rst` and `mem_acc`.
- Forwarding and hazard logic stay in the top level.

## Test plan
- ADD r1 then SUB r2,r1,r3 (`FORWARD_EN`=1): with SUB in EXE, `sel_src_1`=01 and `hazard`=0. One instruction later, a use of r1 in EXE gets select 10.
- LDR r4 then ADD r5,r4,r4: `hazard`=1 for exactly 1 cycle with EXE bubbled. The ADD then has `sel_src_1`=`sel_src_2`=10.
- Both MEM and WB write r6 and the EXE instruction reads r6: select 01, because MEM wins.
- `MEM_WAIT`=4, STR followed immediately by LDR: `freeze`=1 for 3 cycles, then 0 for 1 cycle, then 1 for 3 cycles, then 0 for 1 cycle. Slots do not move during freeze.
- `FORWARD_EN`=0, ADD r1 then ORR r2,r1: `hazard`=1 for 2 cycles and selects stay 00.
- `branch_taken` asserted during a freeze: flush occurs on the release cycle only. `rst` pulsed while in BUSY: next cycle `freeze`=0, FSM in IDLE, all selects 00.
